// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry, FSM encoding and byte-index helpers
// used by the SubBytes/ShiftRows stage and the S-box users.
package aes_pkg;

  localparam int STATE_W   = 128;
  localparam int NUM_BYTES = 16;
  localparam int NUM_ROWS  = 4;
  localparam int NUM_COLS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } aes_state_e;

  // Column-major byte index: s[r + 4c] == {c, r}
  function automatic logic [3:0] idx(input logic [1:0] r, input logic [1:0] c);
    return {c, r};
  endfunction

  // LSB position of byte i in the 128-bit word (s0 sits at [127:120])
  function automatic logic [6:0] byte_lo(input logic [3:0] i);
    return {~i, 3'b000};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// FIPS-197 forward S-box as a purely combinational 256-entry lookup.
module aes_sbox (
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  always_comb begin
    byte_o = 8'h00;
    case (byte_i)
      8'h00: byte_o = 8'h63;  8'h01: byte_o = 8'h7c;  8'h02: byte_o = 8'h77;  8'h03: byte_o = 8'h7b;
      8'h04: byte_o = 8'hf2;  8'h05: byte_o = 8'h6b;  8'h06: byte_o = 8'h6f;  8'h07: byte_o = 8'hc5;
      8'h08: byte_o = 8'h30;  8'h09: byte_o = 8'h01;  8'h0a: byte_o = 8'h67;  8'h0b: byte_o = 8'h2b;
      8'h0c: byte_o = 8'hfe;  8'h0d: byte_o = 8'hd7;  8'h0e: byte_o = 8'hab;  8'h0f: byte_o = 8'h76;
      8'h10: byte_o = 8'hca;  8'h11: byte_o = 8'h82;  8'h12: byte_o = 8'hc9;  8'h13: byte_o = 8'h7d;
      8'h14: byte_o = 8'hfa;  8'h15: byte_o = 8'h59;  8'h16: byte_o = 8'h47;  8'h17: byte_o = 8'hf0;
      8'h18: byte_o = 8'had;  8'h19: byte_o = 8'hd4;  8'h1a: byte_o = 8'ha2;  8'h1b: byte_o = 8'haf;
      8'h1c: byte_o = 8'h9c;  8'h1d: byte_o = 8'ha4;  8'h1e: byte_o = 8'h72;  8'h1f: byte_o = 8'hc0;
      8'h20: byte_o = 8'hb7;  8'h21: byte_o = 8'hfd;  8'h22: byte_o = 8'h93;  8'h23: byte_o = 8'h26;
      8'h24: byte_o = 8'h36;  8'h25: byte_o = 8'h3f;  8'h26: byte_o = 8'hf7;  8'h27: byte_o = 8'hcc;
      8'h28: byte_o = 8'h34;  8'h29: byte_o = 8'ha5;  8'h2a: byte_o = 8'he5;  8'h2b: byte_o = 8'hf1;
      8'h2c: byte_o = 8'h71;  8'h2d: byte_o = 8'hd8;  8'h2e: byte_o = 8'h31;  8'h2f: byte_o = 8'h15;
      8'h30: byte_o = 8'h04;  8'h31: byte_o = 8'hc7;  8'h32: byte_o = 8'h23;  8'h33: byte_o = 8'hc3;
      8'h34: byte_o = 8'h18;  8'h35: byte_o = 8'h96;  8'h36: byte_o = 8'h05;  8'h37: byte_o = 8'h9a;
      8'h38: byte_o = 8'h07;  8'h39: byte_o = 8'h12;  8'h3a: byte_o = 8'h80;  8'h3b: byte_o = 8'he2;
      8'h3c: byte_o = 8'heb;  8'h3d: byte_o = 8'h27;  8'h3e: byte_o = 8'hb2;  8'h3f: byte_o = 8'h75;
      8'h40: byte_o = 8'h09;  8'h41: byte_o = 8'h83;  8'h42: byte_o = 8'h2c;  8'h43: byte_o = 8'h1a;
      8'h44: byte_o = 8'h1b;  8'h45: byte_o = 8'h6e;  8'h46: byte_o = 8'h5a;  8'h47: byte_o = 8'ha0;
      8'h48: byte_o = 8'h52;  8'h49: byte_o = 8'h3b;  8'h4a: byte_o = 8'hd6;  8'h4b: byte_o = 8'hb3;
      8'h4c: byte_o = 8'h29;  8'h4d: byte_o = 8'he3;  8'h4e: byte_o = 8'h2f;  8'h4f: byte_o = 8'h84;
      8'h50: byte_o = 8'h53;  8'h51: byte_o = 8'hd1;  8'h52: byte_o = 8'h00;  8'h53: byte_o = 8'hed;
      8'h54: byte_o = 8'h20;  8'h55: byte_o = 8'hfc;  8'h56: byte_o = 8'hb1;  8'h57: byte_o = 8'h5b;
      8'h58: byte_o = 8'h6a;  8'h59: byte_o = 8'hcb;  8'h5a: byte_o = 8'hbe;  8'h5b: byte_o = 8'h39;
      8'h5c: byte_o = 8'h4a;  8'h5d: byte_o = 8'h4c;  8'h5e: byte_o = 8'h58;  8'h5f: byte_o = 8'hcf;
      8'h60: byte_o = 8'hd0;  8'h61: byte_o = 8'hef;  8'h62: byte_o = 8'haa;  8'h63: byte_o = 8'hfb;
      8'h64: byte_o = 8'h43;  8'h65: byte_o = 8'h4d;  8'h66: byte_o = 8'h33;  8'h67: byte_o = 8'h85;
      8'h68: byte_o = 8'h45;  8'h69: byte_o = 8'hf9;  8'h6a: byte_o = 8'h02;  8'h6b: byte_o = 8'h7f;
      8'h6c: byte_o = 8'h50;  8'h6d: byte_o = 8'h3c;  8'h6e: byte_o = 8'h9f;  8'h6f: byte_o = 8'ha8;
      8'h70: byte_o = 8'h51;  8'h71: byte_o = 8'ha3;  8'h72: byte_o = 8'h40;  8'h73: byte_o = 8'h8f;
      8'h74: byte_o = 8'h92;  8'h75: byte_o = 8'h9d;  8'h76: byte_o = 8'h38;  8'h77: byte_o = 8'hf5;
      8'h78: byte_o = 8'hbc;  8'h79: byte_o = 8'hb6;  8'h7a: byte_o = 8'hda;  8'h7b: byte_o = 8'h21;
      8'h7c: byte_o = 8'h10;  8'h7d: byte_o = 8'hff;  8'h7e: byte_o = 8'hf3;  8'h7f: byte_o = 8'hd2;
      8'h80: byte_o = 8'hcd;  8'h81: byte_o = 8'h0c;  8'h82: byte_o = 8'h13;  8'h83: byte_o = 8'hec;
      8'h84: byte_o = 8'h5f;  8'h85: byte_o = 8'h97;  8'h86: byte_o = 8'h44;  8'h87: byte_o = 8'h17;
      8'h88: byte_o = 8'hc4;  8'h89: byte_o = 8'ha7;  8'h8a: byte_o = 8'h7e;  8'h8b: byte_o = 8'h3d;
      8'h8c: byte_o = 8'h64;  8'h8d: byte_o = 8'h5d;  8'h8e: byte_o = 8'h19;  8'h8f: byte_o = 8'h73;
      8'h90: byte_o = 8'h60;  8'h91: byte_o = 8'h81;  8'h92: byte_o = 8'h4f;  8'h93: byte_o = 8'hdc;
      8'h94: byte_o = 8'h22;  8'h95: byte_o = 8'h2a;  8'h96: byte_o = 8'h90;  8'h97: byte_o = 8'h88;
      8'h98: byte_o = 8'h46;  8'h99: byte_o = 8'hee;  8'h9a: byte_o = 8'hb8;  8'h9b: byte_o = 8'h14;
      8'h9c: byte_o = 8'hde;  8'h9d: byte_o = 8'h5e;  8'h9e: byte_o = 8'h0b;  8'h9f: byte_o = 8'hdb;
      8'ha0: byte_o = 8'he0;  8'ha1: byte_o = 8'h32;  8'ha2: byte_o = 8'h3a;  8'ha3: byte_o = 8'h0a;
      8'ha4: byte_o = 8'h49;  8'ha5: byte_o = 8'h06;  8'ha6: byte_o = 8'h24;  8'ha7: byte_o = 8'h5c;
      8'ha8: byte_o = 8'hc2;  8'ha9: byte_o = 8'hd3;  8'haa: byte_o = 8'hac;  8'hab: byte_o = 8'h62;
      8'hac: byte_o = 8'h91;  8'had: byte_o = 8'h95;  8'hae: byte_o = 8'he4;  8'haf: byte_o = 8'h79;
      8'hb0: byte_o = 8'he7;  8'hb1: byte_o = 8'hc8;  8'hb2: byte_o = 8'h37;  8'hb3: byte_o = 8'h6d;
      8'hb4: byte_o = 8'h8d;  8'hb5: byte_o = 8'hd5;  8'hb6: byte_o = 8'h4e;  8'hb7: byte_o = 8'ha9;
      8'hb8: byte_o = 8'h6c;  8'hb9: byte_o = 8'h56;  8'hba: byte_o = 8'hf4;  8'hbb: byte_o = 8'hea;
      8'hbc: byte_o = 8'h65;  8'hbd: byte_o = 8'h7a;  8'hbe: byte_o = 8'hae;  8'hbf: byte_o = 8'h08;
      8'hc0: byte_o = 8'hba;  8'hc1: byte_o = 8'h78;  8'hc2: byte_o = 8'h25;  8'hc3: byte_o = 8'h2e;
      8'hc4: byte_o = 8'h1c;  8'hc5: byte_o = 8'ha6;  8'hc6: byte_o = 8'hb4;  8'hc7: byte_o = 8'hc6;
      8'hc8: byte_o = 8'he8;  8'hc9: byte_o = 8'hdd;  8'hca: byte_o = 8'h74;  8'hcb: byte_o = 8'h1f;
      8'hcc: byte_o = 8'h4b;  8'hcd: byte_o = 8'hbd;  8'hce: byte_o = 8'h8b;  8'hcf: byte_o = 8'h8a;
      8'hd0: byte_o = 8'h70;  8'hd1: byte_o = 8'h3e;  8'hd2: byte_o = 8'hb5;  8'hd3: byte_o = 8'h66;
      8'hd4: byte_o = 8'h48;  8'hd5: byte_o = 8'h03;  8'hd6: byte_o = 8'hf6;  8'hd7: byte_o = 8'h0e;
      8'hd8: byte_o = 8'h61;  8'hd9: byte_o = 8'h35;  8'hda: byte_o = 8'h57;  8'hdb: byte_o = 8'hb9;
      8'hdc: byte_o = 8'h86;  8'hdd: byte_o = 8'hc1;  8'hde: byte_o = 8'h1d;  8'hdf: byte_o = 8'h9e;
      8'he0: byte_o = 8'he1;  8'he1: byte_o = 8'hf8;  8'he2: byte_o = 8'h98;  8'he3: byte_o = 8'h11;
      8'he4: byte_o = 8'h69;  8'he5: byte_o = 8'hd9;  8'he6: byte_o = 8'h8e;  8'he7: byte_o = 8'h94;
      8'he8: byte_o = 8'h9b;  8'he9: byte_o = 8'h1e;  8'hea: byte_o = 8'h87;  8'heb: byte_o = 8'he9;
      8'hec: byte_o = 8'hce;  8'hed: byte_o = 8'h55;  8'hee: byte_o = 8'h28;  8'hef: byte_o = 8'hdf;
      8'hf0: byte_o = 8'h8c;  8'hf1: byte_o = 8'ha1;  8'hf2: byte_o = 8'h89;  8'hf3: byte_o = 8'h0d;
      8'hf4: byte_o = 8'hbf;  8'hf5: byte_o = 8'he6;  8'hf6: byte_o = 8'h42;  8'hf7: byte_o = 8'h68;
      8'hf8: byte_o = 8'h41;  8'hf9: byte_o = 8'h99;  8'hfa: byte_o = 8'h2d;  8'hfb: byte_o = 8'h0f;
      8'hfc: byte_o = 8'hb0;  8'hfd: byte_o = 8'h54;  8'hfe: byte_o = 8'hbb;  8'hff: byte_o = 8'h16;
    endcase
  end

endmodule

// File: rtl/aes_sub_shift.sv
// Iterative SubBytes + ShiftRows stage: BYTES_PER_CYCLE S-box lanes fill the
// output state a few columns per cycle from a buffered copy of the input block.
module aes_sub_shift
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state
);

  localparam int ITER         = NUM_BYTES / BYTES_PER_CYCLE;
  localparam int COLS_PER_CYC = BYTES_PER_CYCLE / NUM_ROWS;
  localparam int CNT_W        = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  aes_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [STATE_W-1:0] in_buf_q;
  logic [STATE_W-1:0] out_q;
  logic [STATE_W-1:0] out_d;

  logic [3:0] dst_idx [BYTES_PER_CYCLE];
  logic [7:0] sb_in   [BYTES_PER_CYCLE];
  logic [7:0] sb_out  [BYTES_PER_CYCLE];

  // Lane l handles row l%4 of output column cnt*COLS_PER_CYC + l/4; ShiftRows
  // is folded into the read address (source column = dest column + row, mod 4).
  for (genvar l = 0; l < BYTES_PER_CYCLE; l++) begin : g_lane
    localparam logic [1:0] ROW     = 2'(l % NUM_ROWS);
    localparam int         COL_OFS = l / NUM_ROWS;

    logic [1:0] col;
    logic [1:0] src_col;

    assign col        = 2'(int'(cnt_q) * COLS_PER_CYC + COL_OFS);
    assign src_col    = col + ROW;
    assign dst_idx[l] = idx(ROW, col);
    assign sb_in[l]   = in_buf_q[byte_lo(idx(ROW, src_col)) +: 8];

    aes_sbox u_sbox (
      .byte_i (sb_in[l]),
      .byte_o (sb_out[l])
    );
  end

  always_comb begin
    out_d = out_q;
    for (int l = 0; l < BYTES_PER_CYCLE; l++) begin
      out_d[byte_lo(dst_idx[l]) +: 8] = sb_out[l];
    end
  end

  // Input buffer is pure data: loaded on accept, never reset.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && in_valid) begin
      in_buf_q <= in_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          out_q <= out_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_state = out_q;

endmodule

// File: tb/tb_aes_sub_shift.sv
// Bench for aes_sub_shift at 4, 8 and 16 bytes per cycle against a
// GF(2^8)-derived S-box and a row-rotation ShiftRows model.
module tb_aes_sub_shift;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] in_state  [3];
  logic [127:0] out_state [3];

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] sbox_ref [256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_sub_shift #(.BYTES_PER_CYCLE(4 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g])
    );
  end

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] v, int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse, then the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_ref[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_sub_shift(logic [127:0] s);
    logic [7:0]   m  [4][4];
    logic [7:0]   sh [4][4];
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) m[r][c] = s[127 - 8 * (r + 4 * c) -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) sh[r][c] = m[r][(c + r) % 4];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) o[127 - 8 * (r + 4 * c) -: 8] = sbox_ref[sh[r][c]];
    return o;
  endfunction

  function automatic logic [31:0] mix_col0(logic [127:0] s);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = s[127:96];
    return {gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3,
            a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3,
            a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3),
            gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2)};
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(int g, logic [127:0] d);
    int n = 0;
    @(negedge clk);
    in_valid[g] = 1'b1;
    in_state[g] = d;
    while (!in_ready[g] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 128'(n < 100), 128'(1));
    @(posedge clk);
    #1;
    in_valid[g] = 1'b0;
    in_state[g] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_latency(int g, int exp_lat, string tag);
    int lat = 0;
    @(negedge clk);
    while (!out_valid[g] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk(tag, 128'(lat), 128'(exp_lat));
  endtask

  task automatic drain(int g, logic [127:0] exp, string tag);
    chk({tag, "_data"}, out_state[g], exp);
    out_ready[g] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[g] = 1'b0;
    @(negedge clk);
    chk({tag, "_ovld_drop"}, 128'(out_valid[g]), 128'(0));
    chk({tag, "_irdy_back"}, 128'(in_ready[g]), 128'(1));
  endtask

  task automatic random_block(int g);
    logic [127:0] d = {$urandom, $urandom, $urandom, $urandom};
    int n = 0;
    send(g, d);
    @(negedge clk);
    while (n < 200) begin
      out_ready[g] = ($urandom_range(0, 3) != 0);
      if (out_valid[g] && out_ready[g]) break;
      @(negedge clk);
      n++;
    end
    chk("rand_timeout", 128'(n < 200), 128'(1));
    chk($sformatf("rand_g%0d", g), out_state[g], ref_sub_shift(d));
    @(posedge clk);
    #1;
    out_ready[g] = 1'b0;
  endtask

  localparam logic [127:0] APPB_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] APPB_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_sbox();
    for (int g = 0; g < 3; g++) begin
      in_valid[g]  = 1'b0;
      out_ready[g] = 1'b0;
      in_state[g]  = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("reset_irdy_g%0d", g), 128'(in_ready[g]), 128'(1));
      chk($sformatf("reset_ovld_g%0d", g), 128'(out_valid[g]), 128'(0));
      chk($sformatf("reset_out_g%0d", g), out_state[g], 128'h0);
    end
    rst = 1'b0;

    // Directed constant vectors with exact latency
    send(0, 128'h0);
    wait_latency(0, 4, "zero_lat");
    drain(0, {16{8'h63}}, "zero");
    send(0, {16{8'h01}});
    wait_latency(0, 4, "ones_lat");
    drain(0, {16{8'h7c}}, "ones");
    send(0, {16{8'hff}});
    wait_latency(0, 4, "ff_lat");
    drain(0, {16{8'h16}}, "ff");

    // FIPS-197 round-1 vector at each lane count; input changes after accept
    for (int g = 0; g < 3; g++) begin
      send(g, APPB_IN);
      wait_latency(g, 4 >> g, $sformatf("appb_lat_g%0d", g));
      chk($sformatf("appb_mixcol_g%0d", g), 128'(mix_col0(out_state[g])), 128'(32'h046681e5));
      drain(g, APPB_OUT, $sformatf("appb_g%0d", g));
    end

    // Backpressure: result held, no second accept while DONE
    send(0, APPB_IN);
    wait_latency(0, 4, "bp_lat");
    in_valid[0] = 1'b1;
    in_state[0] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 10; i++) begin
      chk("bp_state", out_state[0], APPB_OUT);
      chk("bp_irdy", 128'(in_ready[0]), 128'(0));
      chk("bp_ovld", 128'(out_valid[0]), 128'(1));
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    drain(0, APPB_OUT, "bp");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_no_phantom", 128'(out_valid[0]), 128'(0));
    end

    // Reset in the second BUSY cycle discards the block
    send(0, APPB_IN);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_irdy", 128'(in_ready[0]), 128'(1));
    chk("midrst_ovld", 128'(out_valid[0]), 128'(0));
    chk("midrst_out", out_state[0], 128'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_ovld", 128'(out_valid[0]), 128'(0));
    end
    send(0, 128'h00112233445566778899aabbccddeeff);
    wait_latency(0, 4, "midrst_fresh_lat");
    drain(0, ref_sub_shift(128'h00112233445566778899aabbccddeeff), "midrst_fresh");

    // Random regression with downstream stalls
    for (int i = 0; i < 1000; i++) random_block(0);
    for (int i = 0; i < 100; i++) random_block(1);
    for (int i = 0; i < 100; i++) random_block(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
